// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller.
// Optional feature macro: MIPS_CTRL_ADDI_EN adds the ADDI_EXEC/ADDI_WB states.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9
`ifdef MIPS_CTRL_ADDI_EN
        ,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that wait on mem_ready and are watched by the wait timer.
    function automatic logic is_wait_state(state_t s);
        return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
    endfunction

endpackage

// File: rtl/mips_ctrl_wait_timer.sv
// Counts consecutive stalled cycles in a memory wait state and flags a timeout.
// MEM_WAIT_LIMIT = 0 disables the timeout entirely.
module mips_ctrl_wait_timer #(
    parameter int unsigned MEM_WAIT_LIMIT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wait_active,
    input  logic mem_ready,
    output logic mem_timeout
);

    localparam int unsigned CNT_W = (MEM_WAIT_LIMIT == 0) ? 1 : $clog2(MEM_WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'((MEM_WAIT_LIMIT == 0) ? 1 : MEM_WAIT_LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             timeout_c;

    // Limit reached while still stalled; a same-cycle mem_ready wins.
    assign timeout_c = (MEM_WAIT_LIMIT != 0) && wait_active && !mem_ready
                       && (cnt_q == CNT_W'(MEM_WAIT_LIMIT));
    assign mem_timeout = timeout_c;

    // Saturating stall count, cleared outside wait states, on ready and on timeout.
    always_comb begin
        cnt_d = '0;
        if (wait_active && !mem_ready && !timeout_c) begin
            cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mips_ctrl_fsm.sv
// Multicycle MIPS main controller: fetch/decode/execute/memory/writeback sequencing.
// Optional feature macro: MIPS_CTRL_ADDI_EN (ADDI support; otherwise 6'h08 is illegal).
// Outputs are decoded from the state; all are held at 0 while rst_n is low.
module mips_ctrl_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned OP_WIDTH       = 6,
    parameter int unsigned MEM_WAIT_LIMIT = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OP_WIDTH-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                ir_write,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_source,
    output logic                illegal_op,
    output logic                mem_timeout,
    output logic [3:0]          state_o
);

    localparam logic [OP_WIDTH-1:0] OPC_RTYPE = OP_WIDTH'(OP_RTYPE);
    localparam logic [OP_WIDTH-1:0] OPC_LW    = OP_WIDTH'(OP_LW);
    localparam logic [OP_WIDTH-1:0] OPC_SW    = OP_WIDTH'(OP_SW);
    localparam logic [OP_WIDTH-1:0] OPC_BEQ   = OP_WIDTH'(OP_BEQ);
    localparam logic [OP_WIDTH-1:0] OPC_J     = OP_WIDTH'(OP_J);
    localparam logic [OP_WIDTH-1:0] OPC_ADDI  = OP_WIDTH'(OP_ADDI);

    state_t     state_q;
    state_t     state_d;
    logic       wait_active;
    logic       timeout_w;

    logic       pc_write_c;
    logic       pc_write_cond_c;
    logic       i_or_d_c;
    logic       mem_read_c;
    logic       mem_write_c;
    logic       mem_to_reg_c;
    logic       ir_write_c;
    logic       reg_write_c;
    logic       reg_dst_c;
    logic       alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic [1:0] alu_op_c;
    logic [1:0] pc_source_c;
    logic       illegal_c;

    assign wait_active = is_wait_state(state_q);

    mips_ctrl_wait_timer #(
        .MEM_WAIT_LIMIT (MEM_WAIT_LIMIT)
    ) u_wait_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .wait_active (wait_active),
        .mem_ready   (mem_ready),
        .mem_timeout (timeout_w)
    );

    // Next-state and control decode for the current state.
    always_comb begin
        state_d         = state_q;
        pc_write_c      = 1'b0;
        pc_write_cond_c = 1'b0;
        i_or_d_c        = 1'b0;
        mem_read_c      = 1'b0;
        mem_write_c     = 1'b0;
        mem_to_reg_c    = 1'b0;
        ir_write_c      = 1'b0;
        reg_write_c     = 1'b0;
        reg_dst_c       = 1'b0;
        alu_src_a_c     = 1'b0;
        alu_src_b_c     = SRCB_REG;
        alu_op_c        = ALU_ADD;
        pc_source_c     = PCSRC_ALU;
        illegal_c       = 1'b0;

        case (state_q)
            FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = SRCB_FOUR;
                ir_write_c  = mem_ready;
                pc_write_c  = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                alu_src_b_c = SRCB_IMM_SH2;
                case (opcode)
                    OPC_LW, OPC_SW: state_d = MEM_ADDR;
                    OPC_RTYPE:      state_d = EXECUTE;
                    OPC_BEQ:        state_d = BRANCH;
                    OPC_J:          state_d = JUMP;
                    OPC_ADDI: begin
`ifdef MIPS_CTRL_ADDI_EN
                        state_d = ADDI_EXEC;
`else
                        illegal_c = 1'b1;
                        state_d   = FETCH;
`endif
                    end
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = SRCB_IMM;
                if (opcode == OPC_LW)      state_d = MEM_READ;
                else if (opcode == OPC_SW) state_d = MEM_WRITE;
                else                       state_d = FETCH;
            end
            MEM_READ: begin
                mem_read_c = 1'b1;
                i_or_d_c   = 1'b1;
                if (mem_ready)      state_d = MEM_WB;
                else if (timeout_w) state_d = FETCH;
            end
            MEM_WB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
                state_d      = FETCH;
            end
            MEM_WRITE: begin
                mem_write_c = 1'b1;
                i_or_d_c    = 1'b1;
                if (mem_ready || timeout_w) state_d = FETCH;
            end
            EXECUTE: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = ALU_FUNCT;
                state_d     = R_WB;
            end
            R_WB: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 1'b1;
                state_d     = FETCH;
            end
            BRANCH: begin
                alu_src_a_c     = 1'b1;
                alu_op_c        = ALU_SUB;
                pc_write_cond_c = 1'b1;
                pc_source_c     = PCSRC_ALUOUT;
                state_d         = FETCH;
            end
            JUMP: begin
                pc_write_c  = 1'b1;
                pc_source_c = PCSRC_JUMP;
                state_d     = FETCH;
            end
`ifdef MIPS_CTRL_ADDI_EN
            ADDI_EXEC: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = SRCB_IMM;
                state_d     = ADDI_WB;
            end
            ADDI_WB: begin
                reg_write_c = 1'b1;
                state_d     = FETCH;
            end
`endif
            default: state_d = FETCH;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Force every output low while reset is asserted.
    assign pc_write      = rst_n & pc_write_c;
    assign pc_write_cond = rst_n & pc_write_cond_c;
    assign i_or_d        = rst_n & i_or_d_c;
    assign mem_read      = rst_n & mem_read_c;
    assign mem_write     = rst_n & mem_write_c;
    assign mem_to_reg    = rst_n & mem_to_reg_c;
    assign ir_write      = rst_n & ir_write_c;
    assign reg_write     = rst_n & reg_write_c;
    assign reg_dst       = rst_n & reg_dst_c;
    assign alu_src_a     = rst_n & alu_src_a_c;
    assign alu_src_b     = rst_n ? alu_src_b_c : 2'b00;
    assign alu_op        = rst_n ? alu_op_c : 2'b00;
    assign pc_source     = rst_n ? pc_source_c : 2'b00;
    assign illegal_op    = rst_n & illegal_c;
    assign mem_timeout   = rst_n & timeout_w;
    assign state_o       = rst_n ? 4'(state_q) : 4'd0;

endmodule

// File: doc/mips_ctrl_fsm.md
Name: mips_ctrl_fsm

Overview:
Multicycle MIPS main controller. Decodes the instruction-register opcode and sequences the datapath through fetch, decode, execute, memory and writeback. It sits directly upstream of the datapath 2:1/4:1 muxes and drives every select line they consume (i_or_d, alu_src_a, alu_src_b, mem_to_reg, reg_dst, pc_source). It also drives the register/memory write enables and a memory wait handshake.

Parameters:
OP_WIDTH, 6, opcode field width.
MEM_WAIT_LIMIT, 0, maximum consecutive mem_ready=0 cycles in a wait state; 0 = unbounded.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
opcode  in  OP_WIDTH  IR[31:26]
mem_ready  in  1  memory completes access this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero
i_or_d  out  1  mem address mux select: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
mem_to_reg  out  1  writeback mux select: 0 = ALUOut, 1 = MDR
ir_write  out  1  IR load
reg_write  out  1  register file write
reg_dst  out  1  dest mux select: 0 = rt, 1 = rd
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2
alu_op  out  2  00 = add, 01 = sub, 10 = funct
pc_source  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
illegal_op  out  1  unsupported opcode pulse
mem_timeout  out  1  wait-limit pulse
state_o  out  4  current state, debug

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset: state = FETCH and wait counter = 0. While rst_n = 0, every output is forced to 0, state_o included.
- Output style: Moore decode from state. ir_write, pc_write (in FETCH) and state exits from wait states are qualified by mem_ready (Mealy). Any output not listed for a state = 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write = pc_write = mem_ready. Advance to DECODE on mem_ready, else stay.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - 6'h23 or 6'h2B -> MEM_ADDR
  - 6'h00 -> EXECUTE
  - 6'h04 -> BRANCH
  - 6'h02 -> JUMP
  - 6'h08 -> ADDI_EXEC
  - any other opcode: illegal_op=1 this cycle, next state FETCH
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. LW -> MEM_READ, SW -> MEM_WRITE.
- MEM_READ: mem_read=1, i_or_d=1. Go to MEM_WB on mem_ready.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next state FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Go to FETCH on mem_ready.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Next state R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Next state FETCH.
- JUMP: pc_write=1, pc_source=10. Next state FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Next state ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next state FETCH.
- Latencies with mem_ready=1 throughout: R-type 4 cycles, LW 5, SW 4, BEQ 3, J 3, ADDI 4.
- Wait counter:
  - Counts cycles in FETCH, MEM_READ or MEM_WRITE with mem_ready=0.
  - Clears on any state change or when mem_ready=1.
  - Counter width is $clog2(MEM_WAIT_LIMIT+1); it saturates and never wraps.
- Timeout (MEM_WAIT_LIMIT != 0): when count == MEM_WAIT_LIMIT and mem_ready=0, mem_timeout=1 for one cycle and the counter clears.
  - In FETCH: stay in FETCH, fetch retried.
  - In MEM_READ or MEM_WRITE: go to FETCH, access abandoned, no reg_write.
- Simultaneous mem_ready=1 and limit reached: mem_ready wins, no timeout.
- Reset mid-instruction: immediate return to FETCH, all outputs 0. No partial writeback is issued after rst_n deasserts.
- opcode is sampled only in DECODE and MEM_ADDR; it must be stable during those cycles.

Optional Feature:
MIPS_CTRL_ADDI_EN. When defined, ADDI_EXEC and ADDI_WB exist and 6'h08 decodes as shown above. When undefined, those states are absent and 6'h08 is treated as illegal: illegal_op pulses in DECODE, next state FETCH.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state_t enum (4-bit)
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - alu_op_t constants: ALU_ADD, ALU_SUB, ALU_FUNCT
  - alu_src_b and pc_source encoding constants
- One sub-module, mips_ctrl_wait_timer, holds the wait counter, its saturation and clear logic, and generates mem_timeout.

Test Plan:
- rst_n=0 mid-EXECUTE -> all outputs 0 immediately. After release: state_o=FETCH, mem_read=1.
- opcode=6'h00, mem_ready=1 -> states FETCH, DECODE, EXECUTE, R_WB. alu_op=10 in EXECUTE; reg_write=1 and reg_dst=1 in R_WB; 4 cycles total.
- opcode=6'h23, mem_ready low for 3 cycles in MEM_READ -> i_or_d=1 and mem_read=1 held for 4 cycles. MEM_WB asserts reg_write=1 and mem_to_reg=1.
- opcode=6'h04 then 6'h02 -> BRANCH: pc_write_cond=1, pc_source=01. JUMP: pc_write=1, pc_source=10.
- MEM_WAIT_LIMIT=4, SW with mem_ready=0 forever -> mem_timeout pulses after 4 wait cycles, next state FETCH, mem_write drops.
- opcode=6'h3F, and 6'h08 without MIPS_CTRL_ADDI_EN -> illegal_op=1 in DECODE, no reg_write, return to FETCH.
